// File: rtl/mips_pkg.sv
// Shared constants for the MIPS front end: datapath widths, reset PC and the
// instruction word used as a pipeline bubble.
// Latency: n/a (constants only). Backpressure: n/a.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int JIDX_W = 26;

  // sll $0,$0,0 -- architecturally a no-op, used to fill flushed slots.
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/if_id_register.sv
// IF/ID pipeline register: captures fetched word and its PC+4.
// Latency: 1 cycle from load to outputs.
// Backpressure: load=0 holds contents; flush (or reset) inserts a NOP bubble.
//
// Ports: clk, rst_n (sync, active-low); load, flush controls;
//        instr_in, pc_plus4_in data in; instruction, pc_plus4, valid out.
module if_id_register
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_WORD_P = mips_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [WORD_W-1:0] pc_plus4_in,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              valid
);

  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc_plus4_q, pc_plus4_d;
  logic              valid_q, valid_d;

  // Flush outranks load so a redirect never lets the wrong-path word through.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d    = NOP_WORD_P;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (load) begin
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q    <= NOP_WORD_P;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instruction = instr_q;
  assign pc_plus4    = pc_plus4_q;
  assign valid       = valid_q;

endmodule : if_id_register

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID register.
// Latency: 1 cycle (combinational imem read captured at the edge PC advances).
// Backpressure: Stall holds PC and IF/ID; Branch_taken/Jump override Stall.
//
// Ports: clk, rst_n (sync, active-low); Stall, Branch_taken/Branch_target,
//        Jump/Jump_index controls; Instruction from imem; Read_address to imem
//        (word index); IF_ID_Instruction, IF_ID_PC_plus4, IF_ID_valid out.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = mips_pkg::RESET_PC_DEFAULT,
  parameter logic [WORD_W-1:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Stall,
  input  logic              Branch_taken,
  input  logic [WORD_W-1:0] Branch_target,
  input  logic              Jump,
  input  logic [JIDX_W-1:0] Jump_index,
  input  logic [WORD_W-1:0] Instruction,
  output logic [WORD_W-1:0] Read_address,
  output logic [WORD_W-1:0] IF_ID_Instruction,
  output logic [WORD_W-1:0] IF_ID_PC_plus4,
  output logic              IF_ID_valid
);

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] pc_plus4;
  logic              redirect;
  logic              ifid_load;
  logic [1:0]        unused_target_bits;

  // Natural 32-bit wrap at the top of the address space.
  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = Branch_taken | Jump;
  // Redirect squashes the word being fetched, so it is never loaded.
  assign ifid_load = ~Stall & ~redirect;
  // Targets are word-aligned by truncation; the low bits are intentionally dropped.
  assign unused_target_bits = Branch_target[1:0];

  always_comb begin
    pc_d = pc_plus4;
    if (Branch_taken) begin
      pc_d = {Branch_target[WORD_W-1:2], 2'b00};
    end else if (Jump) begin
      // The jump sits in IF/ID, so its PC+4 region comes from the IF/ID register.
      pc_d = {IF_ID_PC_plus4[WORD_W-1:WORD_W-4], Jump_index, 2'b00};
    end else if (Stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign Read_address = {2'b00, pc_q[WORD_W-1:2]};

  if_id_register #(
    .NOP_WORD_P (NOP_WORD)
  ) u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (ifid_load),
    .flush       (redirect),
    .instr_in    (Instruction),
    .pc_plus4_in (pc_plus4),
    .instruction (IF_ID_Instruction),
    .pc_plus4    (IF_ID_PC_plus4),
    .valid       (IF_ID_valid)
  );

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall;
  logic        Branch_taken;
  logic [31:0] Branch_target;
  logic        Jump;
  logic [25:0] Jump_index;
  logic [31:0] Instruction;
  logic [31:0] Read_address;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PC_plus4;
  logic        IF_ID_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Stall             (Stall),
    .Branch_taken      (Branch_taken),
    .Branch_target     (Branch_target),
    .Jump              (Jump),
    .Jump_index        (Jump_index),
    .Instruction       (Instruction),
    .Read_address      (Read_address),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PC_plus4    (IF_ID_PC_plus4),
    .IF_ID_valid       (IF_ID_valid)
  );

  // Instruction memory model: three program words, then address-tagged fill.
  function automatic logic [31:0] imem(input logic [31:0] ra);
    case (ra)
      32'd0:   imem = 32'h8C01_0000;
      32'd1:   imem = 32'h8C02_0004;
      32'd2:   imem = 32'h0022_1820;
      default: imem = {8'hA5, ra[23:0]};
    endcase
  endfunction

  assign Instruction = imem(Read_address);

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        jmp;
    logic [25:0] jidx;
    logic [31:0] ra;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        v;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] ra;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        v;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic r, logic s, logic b, logic [31:0] t, logic j,
                              logic [25:0] ji, logic [31:0] ra, logic [31:0] ins,
                              logic [31:0] p4, logic v);
    vec_t x;
    x.rst_n = r; x.stall = s; x.br = b; x.tgt = t; x.jmp = j; x.jidx = ji;
    x.ra = ra; x.instr = ins; x.p4 = p4; x.v = v;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b,
                       input logic [31:0] t, input logic j, input logic [25:0] ji);
    rst_n = r; Stall = s; Branch_taken = b; Branch_target = t; Jump = j; Jump_index = ji;
  endtask

  // One edge, then pop the scoreboard entry and compare all outputs.
  task automatic step_and_check;
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.name, ".ra"},    Read_address,      e.ra);
      chk({e.name, ".instr"}, IF_ID_Instruction, e.instr);
      chk({e.name, ".p4"},    IF_ID_PC_plus4,    e.p4);
      chk({e.name, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, e.v});
    end
  endtask

  initial begin
    exp_t        e;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_p4;
    logic        s;

    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);

    //             rst stl br  tgt             jmp jidx          ra            instr          p4             v
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 26'h0,        32'h0,        32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 1, 1, 32'h80,         1, 26'h3,        32'h0,        32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 26'h0,        32'h1,        32'h8C01_0000, 32'h4,         1));
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 26'h0,        32'h2,        32'h8C02_0004, 32'h8,         1));
    vecs.push_back(mk(1, 1, 0, 32'h0,          0, 26'h0,        32'h2,        32'h8C02_0004, 32'h8,         1));
    vecs.push_back(mk(1, 1, 0, 32'h0,          0, 26'h0,        32'h2,        32'h8C02_0004, 32'h8,         1));
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 26'h0,        32'h3,        32'h0022_1820, 32'hC,         1));
    vecs.push_back(mk(1, 0, 1, 32'h42,         0, 26'h0,        32'h10,       32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 26'h0,        32'h11,       32'hA500_0010, 32'h44,        1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 26'h0,        32'h0,        32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 26'h0,        32'h1,        32'h8C01_0000, 32'h4,         1));
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 26'h0,        32'h2,        32'h8C02_0004, 32'h8,         1));
    vecs.push_back(mk(1, 0, 0, 32'h0,          1, 26'h5,        32'h5,        32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 26'h0,        32'h6,        32'hA500_0005, 32'h18,        1));
    vecs.push_back(mk(1, 0, 1, 32'h100,        1, 26'h7,        32'h40,       32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 26'h0,        32'h41,       32'hA500_0040, 32'h104,       1));
    vecs.push_back(mk(1, 1, 1, 32'h203,        0, 26'h0,        32'h80,       32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 1, 0, 32'h0,          1, 26'h3FF_FFFF, 32'h03FF_FFFF, 32'h0,        32'h0,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 26'h0,        32'h0400_0000, 32'hA5FF_FFFF, 32'h1000_0000, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,          1, 26'h1,        32'h0400_0001, 32'h0,        32'h0,         0));
    vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFE,  0, 26'h0,        32'h3FFF_FFFF, 32'h0,        32'h0,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 26'h0,        32'h0,        32'hA5FF_FFFF, 32'h0,         1));
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 26'h0,        32'h1,        32'h8C01_0000, 32'h4,         1));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 26'h9,        32'h0,        32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 26'h0,        32'h1,        32'h8C01_0000, 32'h4,         1));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].jmp, vecs[i].jidx);
      e.name = $sformatf("vec%0d", i);
      e.ra = vecs[i].ra; e.instr = vecs[i].instr; e.p4 = vecs[i].p4; e.v = vecs[i].v;
      sb.push_back(e);
      step_and_check();
    end

    // Random stall bursts on straight-line code: nothing lost or duplicated.
    m_pc = 32'h4; m_instr = 32'h8C01_0000; m_p4 = 32'h4;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      drive(1'b1, s, 1'b0, 32'd0, 1'b0, 26'd0);
      if (!s) begin
        m_instr = imem({2'b00, m_pc[31:2]});
        m_p4    = m_pc + 32'd4;
        m_pc    = m_p4;
      end
      e.name = $sformatf("stall_run%0d", i);
      e.ra = {2'b00, m_pc[31:2]}; e.instr = m_instr; e.p4 = m_p4; e.v = 1'b1;
      sb.push_back(e);
      step_and_check();
    end

    // Free-running wrap from the top of the address space.
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'd0);
    e.name = "wrap_br"; e.ra = 32'h3FFF_FFFF; e.instr = 32'h0; e.p4 = 32'h0; e.v = 1'b0;
    sb.push_back(e);
    step_and_check();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    e.name = "wrap_seq"; e.ra = 32'h0; e.instr = 32'hA5FF_FFFF; e.p4 = 32'h0; e.v = 1'b1;
    sb.push_back(e);
    step_and_check();

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address loaded into PC on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000: instruction word inserted on flush (sll $0,$0,0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 Stall  input  1  hazard-unit hold request for PC and IF/ID.
REQ-006 Branch_taken  input  1  resolved taken branch; redirect to Branch_target.
REQ-007 Branch_target  input  32  branch byte address.
REQ-008 Jump  input  1  decoded J/JAL; redirect to jump target.
REQ-009 Jump_index  input  26  instr_index field of the jump.
REQ-010 Instruction  input  32  combinational word returned by instruction memory for Read_address.
REQ-011 Read_address  output  32  word index into instruction memory.
REQ-012 IF_ID_Instruction  output  32  registered fetched instruction.
REQ-013 IF_ID_PC_plus4  output  32  registered PC+4 of that instruction.
REQ-014 IF_ID_valid  output  1  IF/ID holds a real instruction.

Function
REQ-015 PC SHALL be a 32-bit byte-address register; Read_address SHALL be {2'b00, PC[31:2]}, combinational from PC, zero latency.
REQ-016 Memory read SHALL be treated as combinational: word for PC captured into IF/ID at the same edge PC advances; fetch latency one cycle.
REQ-017 Next-PC priority, highest first: reset, Branch_taken, Jump, Stall, sequential.
REQ-018 Branch_taken=1: PC <= {Branch_target[31:2], 2'b00}; IF/ID flushed; Stall ignored.
REQ-019 Jump=1, Branch_taken=0: PC <= {PC_plus4_of_jump[31:28], Jump_index, 2'b00}, where PC_plus4_of_jump = IF_ID_PC_plus4; IF/ID flushed; Stall ignored.
REQ-020 Flush: IF_ID_Instruction <= NOP_WORD, IF_ID_valid <= 0, IF_ID_PC_plus4 <= 0.
REQ-021 Stall=1, no redirect: PC, IF_ID_Instruction, IF_ID_PC_plus4, IF_ID_valid all hold; Read_address unchanged.
REQ-022 Sequential: PC <= PC+4; IF_ID_Instruction <= Instruction; IF_ID_PC_plus4 <= PC+4; IF_ID_valid <= 1.
REQ-023 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-024 Target low two bits SHALL be forced to zero; no misalignment exception.
REQ-025 Stall and redirect same cycle: redirect wins, no instruction lost or duplicated after release.

Reset
REQ-026 rst_n=0 at rising edge: PC <= RESET_PC, IF_ID_Instruction <= NOP_WORD, IF_ID_PC_plus4 <= 0, IF_ID_valid <= 0; all other inputs ignored.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL override both; first edge after release captures word at RESET_PC.

Structure
REQ-028 Shared package mips_pkg SHALL hold NOP_WORD, RESET_PC default, and width constants (WORD_W=32, JIDX_W=26).
REQ-029 IF/ID pipeline register SHALL be one sub-module if_id_register (inputs load, flush; outputs instruction, pc_plus4, valid); PC and next-PC mux stay in instruction_fetch.

Verification
REQ-030 Reset then 3 free cycles, mem[0..2]=8C010000,8C020004,00221820 -> Read_address 0,1,2,3; IF_ID_Instruction 8C010000,8C020004,00221820; IF_ID_PC_plus4 4,8,C; valid 1 from first edge.
REQ-031 Stall=1 for 2 cycles at PC=8 -> Read_address stays 2, IF/ID holds word1 and PC_plus4=8; release -> word2 captured, PC=C.
REQ-032 Branch_taken=1, Branch_target=32'h0000_0042 at PC=C -> next PC=40, Read_address 16, IF_ID_valid 0, IF_ID_Instruction 0; next edge valid 1.
REQ-033 Jump=1, Jump_index=26'h000_0005, IF_ID_PC_plus4=32'h0000_0008 -> PC=14, Read_address 5, IF/ID flushed; Jump and Branch_taken both 1 -> branch target taken.
REQ-034 Stall=1 with Branch_taken=1 -> redirect applied, flush; PC=32'hFFFF_FFFC free-running -> PC=0, Read_address 0.
REQ-035 rst_n=0 for one edge while Stall=1 and Jump=1 -> PC=RESET_PC, valid 0, NOP in IF/ID.
